// File: rtl/rom_arb_pkg.sv
// ---------------------------------------------------------------------------
// Module   : rom_arb_pkg
// Purpose  : Shared types and defaults for the ROM port arbiter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    D_RD  = 2'd2
  } owner_state_t;

  localparam int c_starve_max_default = 4;

endpackage : rom_arb_pkg

`default_nettype wire

// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : rom_port_arbiter
// Purpose  : Shares one synchronous ROM between instruction fetch and loads,
//            data-first priority with a bounded fetch starvation window.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int STARVE_MAX = c_starve_max_default
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam int                 c_cnt_w      = $clog2(STARVE_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_starve_lim = c_cnt_w'(STARVE_MAX);

  owner_state_t       r_state;
  owner_state_t       w_state_next;
  logic [c_cnt_w-1:0] r_starve;
  logic [31:0]        r_rom_addr;
  logic               r_misalign;

  logic               w_fetch_first;
  logic               w_if_gnt;
  logic               w_d_gnt;
  logic               w_any_gnt;
  logic [31:0]        w_grant_addr;

  // Grants are gated by resetn so nothing is accepted while reset is held.
  assign w_fetch_first = (r_starve == c_starve_lim);
  assign w_if_gnt      = resetn & if_req & (~d_req | w_fetch_first);
  assign w_d_gnt       = resetn & d_req & ~w_if_gnt;
  assign w_any_gnt     = w_if_gnt | w_d_gnt;
  assign w_grant_addr  = w_if_gnt ? if_addr : {d_addr[31:2], 2'b00};

  assign if_gnt   = w_if_gnt;
  assign d_gnt    = w_d_gnt;
  assign rom_addr = w_any_gnt ? w_grant_addr : r_rom_addr;

  // Datapath registers: held ROM address, starvation counter, misalign flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rom_addr <= 32'd0;
      r_starve   <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_any_gnt) begin
        r_rom_addr <= w_grant_addr;
      end
      if (!if_req || w_if_gnt) begin
        r_starve <= '0;
      end else if (w_d_gnt) begin
        r_starve <= r_starve + c_cnt_w'(1);
      end
      r_misalign <= w_d_gnt & (d_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = IDLE;
    if (w_if_gnt) begin
      w_state_next = IF_RD;
    end else if (w_d_gnt) begin
      w_state_next = D_RD;
    end
  end

  // The state names the owner of the ROM word arriving this cycle.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    d_err     = 1'b0;
    case (r_state)
      IF_RD: begin
        if_rvalid = 1'b1;
        if_rdata  = rom_data;
      end
      D_RD: begin
        d_rvalid = 1'b1;
        d_rdata  = rom_data;
        d_err    = r_misalign;
      end
      default: begin
        if_rvalid = 1'b0;
      end
    endcase
  end

endmodule : rom_port_arbiter

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : tb_rom_port_arbiter
// Purpose  : Directed vector bench for rom_port_arbiter with a small ROM model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rom_port_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = 32'd0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rom_port_arbiter #(.STARVE_MAX(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  function automatic logic [31:0] rom_lookup(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom_lookup = 32'h3410_0000;
      32'h0000_0004: rom_lookup = 32'h3411_0001;
      32'h0000_0008: rom_lookup = 32'h8c12_0020;
      32'h0000_000C: rom_lookup = 32'h0220_4025;
      32'h0000_0020: rom_lookup = 32'hac10_0010;
      default:       rom_lookup = 32'hdead_beef;
    endcase
  endfunction

  // Synchronous ROM: word for the sampled address appears one cycle later.
  always @(posedge clock) rom_data <= rom_lookup(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},    {31'd0, if_gnt},    32'd0);
    chk({tag, "_d_gnt"},     {31'd0, d_gnt},     32'd0);
    chk({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    chk({tag, "_if_rdata"},  if_rdata,           32'd0);
    chk({tag, "_d_rvalid"},  {31'd0, d_rvalid},  32'd0);
    chk({tag, "_d_rdata"},   d_rdata,            32'd0);
    chk({tag, "_d_err"},     {31'd0, d_err},     32'd0);
    chk({tag, "_rom_addr"},  rom_addr,           32'd0);
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic [31:0] e_rom_addr;
    logic        e_if_rvalid;
    logic [31:0] e_if_rdata;
    logic        e_d_rvalid;
    logic [31:0] e_d_rdata;
    logic        e_d_err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    bit exp_if;
    bit prev_if;

    // {if_req, if_addr, d_req, d_addr, if_gnt, d_gnt, rom_addr, if_rvalid, if_rdata, d_rvalid, d_rdata, d_err}
    vecs[0]  = '{0, 32'h0, 0, 32'h0,  0, 0, 32'h00, 0, 32'h0,         0, 32'h0,         0};
    vecs[1]  = '{1, 32'h8, 0, 32'h0,  1, 0, 32'h08, 0, 32'h0,         0, 32'h0,         0};
    vecs[2]  = '{0, 32'h0, 0, 32'h0,  0, 0, 32'h08, 1, 32'h8c120020,  0, 32'h0,         0};
    vecs[3]  = '{1, 32'h0, 1, 32'h20, 0, 1, 32'h20, 0, 32'h0,         0, 32'h0,         0};
    vecs[4]  = '{1, 32'h0, 0, 32'h0,  1, 0, 32'h00, 0, 32'h0,         1, 32'hac100010,  0};
    vecs[5]  = '{0, 32'h0, 0, 32'h0,  0, 0, 32'h00, 1, 32'h34100000,  0, 32'h0,         0};
    vecs[6]  = '{0, 32'h0, 1, 32'h22, 0, 1, 32'h20, 0, 32'h0,         0, 32'h0,         0};
    vecs[7]  = '{0, 32'h0, 0, 32'h0,  0, 0, 32'h20, 0, 32'h0,         1, 32'hac100010,  1};
    vecs[8]  = '{1, 32'h0, 0, 32'h0,  1, 0, 32'h00, 0, 32'h0,         0, 32'h0,         0};
    vecs[9]  = '{1, 32'h4, 0, 32'h0,  1, 0, 32'h04, 1, 32'h34100000,  0, 32'h0,         0};
    vecs[10] = '{1, 32'h8, 0, 32'h0,  1, 0, 32'h08, 1, 32'h34110001,  0, 32'h0,         0};
    vecs[11] = '{1, 32'hC, 0, 32'h0,  1, 0, 32'h0C, 1, 32'h8c120020,  0, 32'h0,         0};
    vecs[12] = '{0, 32'h0, 0, 32'h0,  0, 0, 32'h0C, 1, 32'h02204025,  0, 32'h0,         0};
    vecs[13] = '{0, 32'h0, 1, 32'h4,  0, 1, 32'h04, 0, 32'h0,         0, 32'h0,         0};
    vecs[14] = '{0, 32'h0, 0, 32'h0,  0, 0, 32'h04, 0, 32'h0,         1, 32'h34110001,  0};

    // Reset held with both requests asserted: everything must stay at zero.
    resetn  = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h8;
    d_req   = 1'b1;
    d_addr  = 32'h20;
    repeat (2) @(negedge clock);
    #1 chk_all_zero("reset");
    @(negedge clock);
    resetn = 1'b1;
    if_req = 1'b0;
    d_req  = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if_req  = vecs[i].if_req;
      if_addr = vecs[i].if_addr;
      d_req   = vecs[i].d_req;
      d_addr  = vecs[i].d_addr;
      #1;
      chk($sformatf("v%0d_if_gnt", i),    {31'd0, if_gnt},    {31'd0, vecs[i].e_if_gnt});
      chk($sformatf("v%0d_d_gnt", i),     {31'd0, d_gnt},     {31'd0, vecs[i].e_d_gnt});
      chk($sformatf("v%0d_rom_addr", i),  rom_addr,           vecs[i].e_rom_addr);
      chk($sformatf("v%0d_if_rvalid", i), {31'd0, if_rvalid}, {31'd0, vecs[i].e_if_rvalid});
      chk($sformatf("v%0d_if_rdata", i),  if_rdata,           vecs[i].e_if_rdata);
      chk($sformatf("v%0d_d_rvalid", i),  {31'd0, d_rvalid},  {31'd0, vecs[i].e_d_rvalid});
      chk($sformatf("v%0d_d_rdata", i),   d_rdata,            vecs[i].e_d_rdata);
      chk($sformatf("v%0d_d_err", i),     {31'd0, d_err},     {31'd0, vecs[i].e_d_err});
      @(negedge clock);
    end

    // Both requests held: four data grants then one fetch grant, repeating.
    if_req  = 1'b1;
    if_addr = 32'h8;
    d_req   = 1'b1;
    d_addr  = 32'h0;
    prev_if = 1'b0;
    for (int k = 0; k < 15; k++) begin
      exp_if = ((k % 5) == 4);
      #1;
      chk($sformatf("starve%0d_if_gnt", k),   {31'd0, if_gnt}, {31'd0, exp_if});
      chk($sformatf("starve%0d_d_gnt", k),    {31'd0, d_gnt},  {31'd0, ~exp_if});
      chk($sformatf("starve%0d_rom_addr", k), rom_addr,        exp_if ? 32'h8 : 32'h0);
      if (k > 0) begin
        chk($sformatf("starve%0d_if_rvalid", k), {31'd0, if_rvalid}, {31'd0, prev_if});
        chk($sformatf("starve%0d_d_rdata", k),   d_rdata,            prev_if ? 32'h0 : 32'h34100000);
      end
      prev_if = exp_if;
      @(negedge clock);
    end

    // Fetch granted, then reset pulsed before its data returns.
    if_req  = 1'b1;
    if_addr = 32'h8;
    d_req   = 1'b0;
    #1 chk("rst_pre_if_gnt", {31'd0, if_gnt}, 32'd1);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    d_req  = 1'b1;
    d_addr = 32'h20;
    #1 chk_all_zero("rst_flight");
    @(negedge clock);
    @(negedge clock);
    #1 chk_all_zero("rst_held");
    @(negedge clock);
    resetn  = 1'b1;
    d_req   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'hC;
    #1;
    chk("rst_rel_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_rel_if_gnt",    {31'd0, if_gnt},    32'd1);
    chk("rst_rel_rom_addr",  rom_addr,           32'hC);
    @(negedge clock);
    if_req = 1'b0;
    #1;
    chk("rst_first_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("rst_first_if_rdata",  if_rdata,           32'h02204025);
    @(negedge clock);
    #1 chk("end_if_rvalid", {31'd0, if_rvalid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rom_port_arbiter

`default_nettype wire
